// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, square width, move-word layout and
// the scan state encoding used by the rank move generator.
package chess_pkg;

  localparam int SQ_W      = 6;
  localparam int PIECE_W   = 6;
  localparam int MOVE_W    = 32;
  localparam int COLOR_BIT = 3;

  localparam logic [2:0] PT_EMPTY  = 3'd0;
  localparam logic [2:0] PT_PAWN   = 3'd1;
  localparam logic [2:0] PT_KNIGHT = 3'd2;
  localparam logic [2:0] PT_BISHOP = 3'd3;
  localparam logic [2:0] PT_ROOK   = 3'd4;
  localparam logic [2:0] PT_QUEEN  = 3'd5;
  localparam logic [2:0] PT_KING   = 3'd6;
  localparam logic [2:0] PT_NONE   = 3'd7;

  localparam int MV_FROM_LSB  = 26;
  localparam int MV_TO_LSB    = 20;
  localparam int MV_PIECE_LSB = 14;
  localparam int MV_CAPT_LSB  = 8;
  localparam int MV_CAP_FLAG  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  function automatic logic [MOVE_W-1:0] pack_move(
    input logic [SQ_W-1:0]    from_sq,
    input logic [SQ_W-1:0]    to_sq,
    input logic [PIECE_W-1:0] piece,
    input logic [PIECE_W-1:0] captured,
    input logic               cap
  );
    logic [MOVE_W-1:0] w;
    w = {MOVE_W{1'b0}};
    w[MV_FROM_LSB  +: SQ_W]    = from_sq;
    w[MV_TO_LSB    +: SQ_W]    = to_sq;
    w[MV_PIECE_LSB +: PIECE_W] = piece;
    w[MV_CAPT_LSB  +: PIECE_W] = captured;
    w[MV_CAP_FLAG]             = cap;
    return w;
  endfunction

  // Type 7 is an unused code and behaves as an empty square.
  function automatic logic is_empty(input logic [2:0] ptype);
    return (ptype == PT_EMPTY) || (ptype == PT_NONE);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on dout whenever not empty.
module move_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout    = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/rank_slide_movegen.sv
// Serial horizontal move generator for one rank: scans rook/queen/king rays
// left then right per origin and queues move words for the move collector.
module rank_slide_movegen #(
  parameter int NUM_SQ     = 8,
  parameter int RANK       = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                start,
  input  logic                engine_color,
  input  logic [6*NUM_SQ-1:0] row_pieces,
  output logic                busy,
  output logic                done,
  output logic                move_valid,
  output logic [31:0]         move_data,
  input  logic                move_ready,
  output logic [7:0]          move_count
);

  import chess_pkg::*;

  localparam logic [SQ_W-1:0] RANK_BASE = SQ_W'(RANK * 8);
  localparam logic [2:0]      LAST_SQ   = 3'(NUM_SQ - 1);

  scan_state_t      state_r, state_s;
  logic [5:0]       sq_r [8];
  logic             color_r;
  logic [2:0]       origin_r, origin_s;
  logic             dir_r, dir_s;      // 0: toward file 0, 1: toward higher files
  logic [2:0]       dist_r, dist_s;
  logic             busy_r, done_r, done_s;
  logic [7:0]       count_r;
  logic [47:0]      row_pad_s;
  logic [3:0]       tgt_s;
  logic             off_board_s;
  logic [5:0]       org_piece_s, tgt_piece_s;
  logic             qualifies_s;
  logic             push_s, end_ray_s, next_org_s;
  logic [31:0]      push_data_s;
  logic             fifo_full_s, fifo_empty_s, pop_s;

  assign row_pad_s   = 48'(row_pieces);
  assign org_piece_s = sq_r[origin_r];
  // Left targets below file 0 wrap into bit 3, as do right targets past file 7.
  assign tgt_s       = dir_r ? ({1'b0, origin_r} + {1'b0, dist_r})
                             : ({1'b0, origin_r} - {1'b0, dist_r});
  assign off_board_s = tgt_s[3] || (tgt_s[2:0] > LAST_SQ);
  assign tgt_piece_s = sq_r[tgt_s[2:0]];
  assign qualifies_s = ((org_piece_s[2:0] == PT_ROOK) || (org_piece_s[2:0] == PT_QUEEN) ||
                        (org_piece_s[2:0] == PT_KING)) && (org_piece_s[COLOR_BIT] == color_r);
  assign pop_s       = move_valid && move_ready;

  // Next-state, candidate evaluation and push request.
  always_comb begin
    state_s     = state_r;
    origin_s    = origin_r;
    dir_s       = dir_r;
    dist_s      = dist_r;
    push_s      = 1'b0;
    push_data_s = 32'd0;
    end_ray_s   = 1'b0;
    next_org_s  = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_SCAN;
          origin_s = 3'd0;
          dir_s    = 1'b0;
          dist_s   = 3'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!fifo_full_s) begin
          if (!qualifies_s) begin
            next_org_s = 1'b1;
          end else if (off_board_s) begin
            end_ray_s = 1'b1;
          end else if (is_empty(tgt_piece_s[2:0])) begin
            push_s      = 1'b1;
            push_data_s = pack_move(RANK_BASE | {3'd0, origin_r}, RANK_BASE | {3'd0, tgt_s[2:0]},
                                    org_piece_s, 6'd0, 1'b0);
            if (org_piece_s[2:0] == PT_KING) begin
              end_ray_s = 1'b1;
            end else begin
              dist_s = dist_r + 3'd1;
            end
          end else if (tgt_piece_s[COLOR_BIT] != color_r) begin
            push_s      = 1'b1;
            push_data_s = pack_move(RANK_BASE | {3'd0, origin_r}, RANK_BASE | {3'd0, tgt_s[2:0]},
                                    org_piece_s, tgt_piece_s, 1'b1);
            end_ray_s   = 1'b1;
          end else begin
            end_ray_s = 1'b1;
          end

          if (end_ray_s) begin
            if (!dir_r) begin
              dir_s  = 1'b1;
              dist_s = 3'd1;
            end else begin
              next_org_s = 1'b1;
            end
          end else begin
            next_org_s = next_org_s;
          end

          if (next_org_s) begin
            if (origin_r == LAST_SQ) begin
              state_s = ST_DRAIN;
            end else begin
              origin_s = origin_r + 3'd1;
              dir_s    = 1'b0;
              dist_s   = 3'd1;
            end
          end else begin
            state_s = ST_SCAN;
          end
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scan state, latched rank contents and registered status outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r  <= ST_IDLE;
      color_r  <= 1'b0;
      origin_r <= 3'd0;
      dir_r    <= 1'b0;
      dist_r   <= 3'd1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      count_r  <= 8'd0;
      for (int f = 0; f < 8; f++) begin
        sq_r[f] <= 6'd0;
      end
    end else begin
      state_r  <= state_s;
      origin_r <= origin_s;
      dir_r    <= dir_s;
      dist_r   <= dist_s;
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= done_s;
      if ((state_r == ST_IDLE) && start) begin
        color_r <= engine_color;
        count_r <= 8'd0;
        for (int f = 0; f < 8; f++) begin
          sq_r[f] <= (f < NUM_SQ) ? row_pad_s[6*f +: 6] : 6'd0;
        end
      end else if (push_s && (count_r != 8'd255)) begin
        count_r <= count_r + 8'd1;
      end
    end
  end

  move_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (clear_n),
    .push  (push_s),
    .din   (push_data_s),
    .pop   (pop_s),
    .dout  (move_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign move_valid = !fifo_empty_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign move_count = count_r;

endmodule
